// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared constants and types for the two-master register bank arbiter:
//   DATA_W / ADDR_W      register width and register-select width
//   state_t              arbiter FSM states (IDLE, ACCESS, RESP)
//   mst_t                master index (M0, M1)
//   RB_R0_INIT..R3_INIT  bank contents after reset
// -----------------------------------------------------------------------------
package regbank_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      MST_M0 = 1'b0,
      MST_M1 = 1'b1
   } mst_t;

   localparam logic [DATA_W-1:0] RB_R0_INIT = 16'h100A;
   localparam logic [DATA_W-1:0] RB_R1_INIT = 16'h200B;
   localparam logic [DATA_W-1:0] RB_R2_INIT = 16'h300C;
   localparam logic [DATA_W-1:0] RB_R3_INIT = 16'h0000;

endpackage

// File: rtl/regbank_arbiter_if.sv
// -----------------------------------------------------------------------------
// regbank_arbiter_if
// Bundles both master ports of the register bank arbiter.
//   mX_req/rw/addr/wdata  master -> arbiter transaction request (rw: 1=read)
//   mX_gnt                arbiter -> master, master owns the bank (ACCESS)
//   mX_ack                arbiter -> master, one-cycle completion pulse
//   mX_rdata              arbiter -> master, last read data for that master
//   busy                  arbiter -> masters, FSM not in IDLE
// Modports: master (bench / bus side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface regbank_arbiter_if;
   import regbank_pkg::*;

   logic              m0_req;
   logic              m0_rw;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_rw;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   logic              busy;

   modport master (
      output m0_req, m0_rw, m0_addr, m0_wdata,
      output m1_req, m1_rw, m1_addr, m1_wdata,
      input  m0_gnt, m0_ack, m0_rdata,
      input  m1_gnt, m1_ack, m1_rdata,
      input  busy
   );

   modport slave (
      input  m0_req, m0_rw, m0_addr, m0_wdata,
      input  m1_req, m1_rw, m1_addr, m1_wdata,
      output m0_gnt, m0_ack, m0_rdata,
      output m1_gnt, m1_ack, m1_rdata,
      output busy
   );

endinterface

// File: rtl/regbank_core_4x16.sv
// -----------------------------------------------------------------------------
// regbank_core_4x16
// Four 16-bit general-purpose registers.
//   clk, rst        clock, asynchronous active-high reset (loads init values)
//   we/waddr/wdata  synchronous write port
//   re/raddr/rdata  registered read port (rdata updates on the edge re is high)
// -----------------------------------------------------------------------------
module regbank_core_4x16
   import regbank_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] regs [4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs[0] <= RB_R0_INIT;
         regs[1] <= RB_R1_INIT;
         regs[2] <= RB_R2_INIT;
         regs[3] <= RB_R3_INIT;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= regs[raddr];
      end
   end

endmodule

// File: rtl/regbank_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_arbiter
// Shares one 4x16 register bank between two masters. One transaction at a
// time runs through IDLE -> ACCESS -> RESP; the winner sees gnt in ACCESS and
// a one-cycle ack in RESP, with read data valid from the ack cycle.
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   regbank_arbiter_if.slave (both master ports plus busy)
// Build option: define REGBANK_FIXED_PRIO_EN for fixed priority (M0 always
// wins a tie); otherwise round-robin on the last-served master.
// -----------------------------------------------------------------------------
module regbank_arbiter
   import regbank_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   regbank_arbiter_if.slave bus
);

   state_t            state, state_nxt;
   mst_t              win, cur_mst;
   logic              start, core_we, cur_rw, sel_rw;
   logic [ADDR_W-1:0] sel_addr, cur_addr;
   logic [DATA_W-1:0] sel_wdata, cur_wdata, core_rdata;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;

`ifdef REGBANK_FIXED_PRIO_EN
   always_comb begin
      win = bus.m0_req ? MST_M0 : MST_M1;
   end
`else
   mst_t last;

   always_comb begin
      if (bus.m0_req && bus.m1_req) begin
         win = (last == MST_M1) ? MST_M0 : MST_M1;
      end else if (bus.m0_req) begin
         win = MST_M0;
      end else begin
         win = MST_M1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= MST_M1;
      end else if (start) begin
         last <= win;
      end
   end
`endif

   always_comb begin
      if (win == MST_M0) begin
         sel_rw    = bus.m0_rw;
         sel_addr  = bus.m0_addr;
         sel_wdata = bus.m0_wdata;
      end else begin
         sel_rw    = bus.m1_rw;
         sel_addr  = bus.m1_addr;
         sel_wdata = bus.m1_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      core_we   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               start     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            core_we   = !cur_rw;
            state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Transaction latch: winner identity is control, address/data are not reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_mst <= MST_M0;
         cur_rw  <= 1'b0;
      end else if (start) begin
         cur_mst <= win;
         cur_rw  <= sel_rw;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         cur_addr  <= sel_addr;
         cur_wdata <= sel_wdata;
      end
   end

   // The core read is launched on the IDLE->ACCESS edge so its registered
   // output is ready during ACCESS; no write can intervene inside one
   // transaction, so this equals the bank value at the ACCESS closing edge.
   regbank_core_4x16 u_core (
      .clk   (clk),
      .rst   (rst),
      .we    (core_we),
      .waddr (cur_addr),
      .wdata (cur_wdata),
      .re    (start),
      .raddr (sel_addr),
      .rdata (core_rdata)
   );

   // Per-master read data, captured at the ACCESS closing edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else if (state == ACCESS && cur_rw) begin
         if (cur_mst == MST_M0) begin
            m0_rdata <= core_rdata;
         end else begin
            m1_rdata <= core_rdata;
         end
      end
   end

   assign bus.m0_gnt   = (state == ACCESS) && (cur_mst == MST_M0);
   assign bus.m1_gnt   = (state == ACCESS) && (cur_mst == MST_M1);
   assign bus.m0_ack   = (state == RESP)   && (cur_mst == MST_M0);
   assign bus.m1_ack   = (state == RESP)   && (cur_mst == MST_M1);
   assign bus.m0_rdata = m0_rdata;
   assign bus.m1_rdata = m1_rdata;
   assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_regbank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbank_arbiter
// Scoreboard bench for regbank_arbiter: directed scenarios followed by random
// traffic from both masters. A behavioural model (bank array, service slots
// of three cycles, arbitration rule) pushes expected responses; a negedge
// monitor pops and compares them and checks gnt/busy/rdata every cycle.
// -----------------------------------------------------------------------------
module tb_regbank_arbiter;
   import regbank_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   regbank_arbiter_if bus ();

   regbank_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          mst;
      bit          rd;
      logic [15:0] data;
      int          ack_edge;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] bank [4];
   logic [15:0] exp_rd [2];
   int          edge_n    = 0;
   int          free_at   = 0;
   int          last_m    = 1;
   int          cur_win   = 0;
   int          cur_start = -100;

   initial begin : model
      int          w;
      logic [1:0]  a;
      logic [15:0] wd;
      exp_t        e;
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            bank[0] = 16'h100A; bank[1] = 16'h200B;
            bank[2] = 16'h300C; bank[3] = 16'h0000;
            last_m = 1; free_at = 0; cur_start = -100;
            sbq.delete();
         end else if (edge_n >= free_at && (bus.m0_req || bus.m1_req)) begin
`ifdef REGBANK_FIXED_PRIO_EN
            w = bus.m0_req ? 0 : 1;
`else
            if (bus.m0_req && bus.m1_req) w = 1 - last_m;
            else w = bus.m0_req ? 0 : 1;
`endif
            e.mst      = w;
            e.rd       = (w == 1) ? bus.m1_rw : bus.m0_rw;
            a          = (w == 1) ? bus.m1_addr : bus.m0_addr;
            wd         = (w == 1) ? bus.m1_wdata : bus.m0_wdata;
            e.ack_edge = edge_n + 1;
            if (e.rd) begin
               e.data = bank[a];
            end else begin
               e.data  = 16'h0;
               bank[a] = wd;
            end
            sbq.push_back(e);
            last_m    = w;
            cur_win   = w;
            cur_start = edge_n;
            free_at   = edge_n + 3;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      bit   due;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_rd[0] = 16'h0;
            exp_rd[1] = 16'h0;
         end else begin
            due = (sbq.size() > 0) && (sbq[0].ack_edge <= edge_n);
            if (bus.m0_ack || bus.m1_ack || due) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("ack_m0", 32'(bus.m0_ack), 32'(e.mst == 0));
                  chk("ack_m1", 32'(bus.m1_ack), 32'(e.mst == 1));
                  chk("ack_cycle", 32'(edge_n), 32'(e.ack_edge));
                  if (e.rd) exp_rd[e.mst] = e.data;
               end
            end
            chk("m0_rdata", 32'(bus.m0_rdata), 32'(exp_rd[0]));
            chk("m1_rdata", 32'(bus.m1_rdata), 32'(exp_rd[1]));
            chk("m0_gnt", 32'(bus.m0_gnt), 32'(edge_n == cur_start && cur_win == 0));
            chk("m1_gnt", 32'(bus.m1_gnt), 32'(edge_n == cur_start && cur_win == 1));
            chk("busy", 32'(bus.busy), 32'(edge_n == cur_start || edge_n == cur_start + 1));
            chk("gnt_ack_exclusive", 32'({bus.m0_gnt & bus.m1_gnt, bus.m0_ack & bus.m1_ack}), 32'd0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int m, input bit req, input bit rw,
                        input logic [1:0] a, input logic [15:0] d);
      if (m == 0) begin
         bus.m0_req = req; bus.m0_rw = rw; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = req; bus.m1_rw = rw; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   function automatic bit ack_of(input int m);
      return (m == 0) ? bus.m0_ack : bus.m1_ack;
   endfunction

   function automatic bit gnt_of(input int m);
      return (m == 0) ? bus.m0_gnt : bus.m1_gnt;
   endfunction

   task automatic wait_ack(input int m, output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack_of(m)) begin
            n = i;
            break;
         end
      end
      chk("ack_timeout", 32'(n != 0), 32'd1);
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic driver(input int m, input int cycles);
      bit pending = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (pending && ack_of(m)) begin
            pending = 0;
            set_m(m, 0, 0, 2'd0, 16'h0);
            if ($urandom_range(0, 1) == 1) begin
               set_m(m, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
               pending = 1;
            end
         end else if (pending && gnt_of(m) && $urandom_range(0, 3) == 0) begin
            set_m(m, 0, 0, 2'd0, 16'h0);
         end else if (!pending && $urandom_range(0, 2) == 0) begin
            set_m(m, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
            pending = 1;
         end
      end
      set_m(m, 0, 0, 2'd0, 16'h0);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin : stim
      int n;
      int cnt;
      int order[$];
      int exp_o;
      set_m(0, 0, 0, 2'd0, 16'h0);
      set_m(1, 0, 0, 2'd0, 16'h0);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // M0 reads R1 from reset: gnt one cycle after sampling, ack the next.
      set_m(0, 1, 1, 2'd1, 16'h0);
      tick();
      chk("t1_gnt", 32'(bus.m0_gnt), 32'd1);
      chk("t1_no_early_ack", 32'(bus.m0_ack), 32'd0);
      tick();
      chk("t1_ack", 32'(bus.m0_ack), 32'd1);
      chk("t1_rdata", 32'(bus.m0_rdata), 32'h200B);
      chk("t1_m1_quiet", 32'({bus.m1_gnt, bus.m1_ack, bus.m1_rdata}), 32'd0);
      set_m(0, 0, 0, 2'd0, 16'h0);
      tick();
      chk("t1_ack_pulse", 32'(bus.m0_ack), 32'd0);
      chk("t1_idle", 32'(bus.busy), 32'd0);
      repeat (2) tick();

      // M1 writes BEEF to R3, M0 issues a read of R3 in M1's ack cycle.
      set_m(1, 1, 0, 2'd3, 16'hBEEF);
      wait_ack(1, n);
      set_m(1, 0, 0, 2'd0, 16'h0);
      set_m(0, 1, 1, 2'd3, 16'h0);
      wait_ack(0, n);
      chk("t2_latency", 32'(n), 32'd3);
      chk("t2_raw", 32'(bus.m0_rdata), 32'hBEEF);
      set_m(0, 0, 0, 2'd0, 16'h0);
      repeat (3) tick();

      // Both masters read R0 continuously from reset.
      do_reset();
      set_m(0, 1, 1, 2'd0, 16'h0);
      set_m(1, 1, 1, 2'd0, 16'h0);
      repeat (18) begin
         tick();
         if (bus.m0_ack) order.push_back(0);
         if (bus.m1_ack) order.push_back(1);
      end
      set_m(0, 0, 0, 2'd0, 16'h0);
      set_m(1, 0, 0, 2'd0, 16'h0);
      chk("t3_count", 32'(order.size()), 32'd6);
      for (int i = 0; i < 4; i++) begin
         if (i < order.size()) begin
`ifdef REGBANK_FIXED_PRIO_EN
            exp_o = 0;
`else
            exp_o = i % 2;
`endif
            chk("t3_order", 32'(order[i]), 32'(exp_o));
         end
      end
      repeat (4) tick();

      // M0 drops req right after being sampled: exactly one ack follows.
      set_m(0, 1, 1, 2'd2, 16'h0);
      tick();
      chk("t4_gnt", 32'(bus.m0_gnt), 32'd1);
      set_m(0, 0, 0, 2'd0, 16'h0);
      cnt = 0;
      repeat (8) begin
         tick();
         if (bus.m0_ack) cnt++;
      end
      chk("t4_single_ack", 32'(cnt), 32'd1);

      // Reset during ACCESS of a write: no ack, write does not land.
      set_m(0, 1, 0, 2'd2, 16'h1234);
      tick();
      chk("t5_gnt", 32'(bus.m0_gnt), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_m(0, 0, 0, 2'd0, 16'h0);
      cnt = 0;
      repeat (4) begin
         tick();
         if (bus.m0_ack) cnt++;
      end
      chk("t5_no_ack", 32'(cnt), 32'd0);
      set_m(0, 1, 1, 2'd2, 16'h0);
      wait_ack(0, n);
      chk("t5_rdata", 32'(bus.m0_rdata), 32'h300C);
      set_m(0, 0, 0, 2'd0, 16'h0);
      repeat (3) tick();

      // Random traffic from both masters.
      fork
         driver(0, 600);
         driver(1, 600);
      join
      repeat (10) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
